seg7_bcd_counter: RTL and testbench

Parametrised multi-digit up/down counter with built-in tick prescaler, terminal-count pulse, auto-reload and multiplexed 7-segment drive. It is the next generation of the single-digit ripple countdown/7-segment projects in this design. It replaces ripple flip-flops and hand-built decode with one fully synchronous block, generalised in digit count, direction and rate. It sits between a user project's `io_in` and `io_out` pins and drives a common display directly.

---
 rtl/seg7_pkg.sv | 65 ++++++
 rtl/bcd_digit.sv | 35 +++
 rtl/seg7_bcd_counter.sv | 120 ++++++++++++
 tb/tb_seg7_bcd_counter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared digit type, segment patterns and decode for the 7-segment counter.
// SEG7_BCD_COUNTER_HEX_EN selects hex digits; the default build is BCD.
package seg7_pkg;

    typedef logic [3:0] digit_t;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

`ifdef SEG7_BCD_COUNTER_HEX_EN
    localparam digit_t DIGIT_MAX = 4'd15;
`else
    localparam digit_t DIGIT_MAX = 4'd9;
`endif

    function automatic logic [6:0] seg7_decode(input digit_t d);
        logic [6:0] s;
        case (d)
            4'h0:    s = SEG_0;
            4'h1:    s = SEG_1;
            4'h2:    s = SEG_2;
            4'h3:    s = SEG_3;
            4'h4:    s = SEG_4;
            4'h5:    s = SEG_5;
            4'h6:    s = SEG_6;
            4'h7:    s = SEG_7;
            4'h8:    s = SEG_8;
            4'h9:    s = SEG_9;
`ifdef SEG7_BCD_COUNTER_HEX_EN
            4'hA:    s = SEG_A;
            4'hB:    s = SEG_B;
            4'hC:    s = SEG_C;
            4'hD:    s = SEG_D;
            4'hE:    s = SEG_E;
            4'hF:    s = SEG_F;
`endif
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    function automatic digit_t clamp_digit(input digit_t d);
`ifdef SEG7_BCD_COUNTER_HEX_EN
        return d;
`else
        return (d > DIGIT_MAX) ? DIGIT_MAX : d;
`endif
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One counter digit with ripple carry/borrow; digit 0 takes cin tied high.
// Wraps between 0 and DIGIT_MAX; loads are clamped in BCD builds.
module bcd_digit
    import seg7_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       step,
    input  logic       up_dn,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       cin,
    output logic [3:0] q,
    output logic       cout
);

    // Carry/borrow depends only on direction, so wrap detection can
    // feed the reload decision without a combinational loop.
    assign cout = cin & (up_dn ? (q == DIGIT_MAX) : (q == 4'd0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 4'd0;
        end else if (load) begin
            q <= clamp_digit(load_val);
        end else if (step && cin) begin
            if (up_dn) begin
                q <= (q == DIGIT_MAX) ? 4'd0 : q + 4'd1;
            end else begin
                q <= (q == 4'd0) ? DIGIT_MAX : q - 4'd1;
            end
        end
    end

endmodule

// File: rtl/seg7_bcd_counter.sv
// Multi-digit up/down counter with prescaler, tc, reload and 7-seg scan.
// Define SEG7_BCD_COUNTER_HEX_EN for hex digits and A-F decode.
module seg7_bcd_counter
    import seg7_pkg::*;
#(
    parameter int DIGITS   = 2,
    parameter int PRESCALE = 1000,
    parameter int MUX_DIV  = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  load,
    input  logic                  reload,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     digit_sel
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int MW = (MUX_DIV > 1) ? $clog2(MUX_DIV) : 1;
    localparam int SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [PW-1:0]     pre;
    logic              tick;
    logic              step;
    logic              dig_load;
    logic              wrap;
    logic [DIGITS:0]   carry;
    logic [3:0]        digits [DIGITS];

    logic [MW-1:0]     mux_cnt;
    logic [SW-1:0]     scan_idx;
    logic              mux_last;
    logic [3:0]        sel_digit;
    logic [DIGITS-1:0] sel_onehot;

    assign tick = en && (pre == PW'(PRESCALE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre <= '0;
        end else if (load) begin
            pre <= '0;
        end else if (en) begin
            pre <= tick ? '0 : pre + 1'b1;
        end
    end

    // Load beats tick; a wrap with reload is just a load of load_val.
    assign wrap     = tick & carry[DIGITS];
    assign step     = tick & ~load;
    assign dig_load = load | (wrap & reload);
    assign carry[0] = 1'b1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        bcd_digit u_digit (
            .clk      (clk),
            .rst_n    (rst_n),
            .step     (step),
            .up_dn    (up_dn),
            .load     (dig_load),
            .load_val (load_val[4*i +: 4]),
            .cin      (carry[i]),
            .q        (digits[i]),
            .cout     (carry[i+1])
        );
        assign count[4*i +: 4] = digits[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tc <= 1'b0;
        end else begin
            tc <= wrap & ~load;
        end
    end

    assign mux_last = (mux_cnt == MW'(MUX_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mux_cnt  <= '0;
            scan_idx <= '0;
        end else if (mux_last) begin
            mux_cnt  <= '0;
            scan_idx <= (scan_idx == SW'(DIGITS - 1)) ? '0 : scan_idx + 1'b1;
        end else begin
            mux_cnt  <= mux_cnt + 1'b1;
        end
    end

    always_comb begin
        sel_digit  = 4'd0;
        sel_onehot = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (scan_idx == SW'(i)) begin
                sel_digit     = digits[i];
                sel_onehot[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg       <= SEG_0;
            dp        <= 1'b0;
            digit_sel <= DIGITS'(1);
        end else begin
            seg       <= seg7_decode(sel_digit);
            dp        <= (scan_idx == '0) && !en;
            digit_sel <= sel_onehot;
        end
    end

endmodule

// File: tb/tb_seg7_bcd_counter.sv
// Directed bench: fast instance (PRESCALE=1) and slow instance (PRESCALE=4).
// Expectations follow SEG7_BCD_COUNTER_HEX_EN when it is defined.
module tb_seg7_bcd_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       up_dn;
    logic       load;
    logic       reload;
    logic [7:0] load_val;

    logic [7:0] f_count, s_count;
    logic       f_tc, s_tc;
    logic [6:0] f_seg, s_seg;
    logic       f_dp, s_dp;
    logic [1:0] f_sel, s_sel;

    int checks = 0;
    int errors = 0;

`ifdef SEG7_BCD_COUNTER_HEX_EN
    localparam logic [7:0] MAXV  = 8'hFF;
    localparam logic [7:0] CL3C  = 8'h3C;
    localparam logic [7:0] UP19  = 8'h1A;
    localparam logic [7:0] CLA5  = 8'hA5;
    localparam logic [7:0] DNA5  = 8'hA4;
    localparam logic [6:0] SEG3C = 7'h39;
    localparam int         NFULL = 256;
`else
    localparam logic [7:0] MAXV  = 8'h99;
    localparam logic [7:0] CL3C  = 8'h39;
    localparam logic [7:0] UP19  = 8'h20;
    localparam logic [7:0] CLA5  = 8'h95;
    localparam logic [7:0] DNA5  = 8'h94;
    localparam logic [6:0] SEG3C = 7'h6F;
    localparam int         NFULL = 100;
`endif

    always #5 clk = ~clk;

    seg7_bcd_counter #(.DIGITS(2), .PRESCALE(1), .MUX_DIV(4)) u_fast (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn),
        .load(load), .reload(reload), .load_val(load_val),
        .count(f_count), .tc(f_tc), .seg(f_seg), .dp(f_dp),
        .digit_sel(f_sel)
    );

    seg7_bcd_counter #(.DIGITS(2), .PRESCALE(4), .MUX_DIV(4)) u_slow (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn),
        .load(load), .reload(reload), .load_val(load_val),
        .count(s_count), .tc(s_tc), .seg(s_seg), .dp(s_dp),
        .digit_sel(s_sel)
    );

    typedef struct {
        logic       ld;
        logic [7:0] lv;
        logic       en;
        logic       up;
        logic       rl;
        logic [7:0] exp_count;
        logic       exp_tc;
        string      name;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic l, input logic [7:0] v, input logic e,
                         input logic u, input logic r);
        load     = l;
        load_val = v;
        en       = e;
        up_dn    = u;
        reload   = r;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 8'h10, 1'b0, "ld10"};
        vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h09, 1'b0, "dn10"};
        vecs[2]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, "ld00"};
        vecs[3]  = '{1'b0, 8'h25, 1'b1, 1'b0, 1'b1, 8'h25, 1'b1, "reload"};
        vecs[4]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, "ld00b"};
        vecs[5]  = '{1'b0, 8'h25, 1'b1, 1'b0, 1'b0, MAXV,  1'b1, "dnwrap"};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, "upwrap"};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h01, 1'b0, "up01"};
        vecs[8]  = '{1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, CL3C,  1'b0, "clamp3c"};
        vecs[9]  = '{1'b1, 8'h19, 1'b1, 1'b1, 1'b0, 8'h19, 1'b0, "ldwins"};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, UP19,  1'b0, "carry"};
        vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, UP19,  1'b0, "hold"};
        vecs[12] = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, CLA5,  1'b0, "clampa5"};
        vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, DNA5,  1'b0, "dna5"};

        rst_n = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        #12;
        chk("rst_count", 32'(f_count), 32'h00);
        chk("rst_seg", 32'(f_seg), 32'h3F);
        chk("rst_sel", 32'(f_sel), 32'h1);
        chk("rst_tc", 32'(f_tc), 32'h0);
        chk("rst_dp", 32'(f_dp), 32'h0);
        rst_n = 1'b1;

        // Table of single-cycle steps on the PRESCALE=1 instance.
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].ld, vecs[i].lv, vecs[i].en, vecs[i].up, vecs[i].rl);
            step();
            chk({vecs[i].name, "_count"}, 32'(f_count), 32'(vecs[i].exp_count));
            chk({vecs[i].name, "_tc"}, 32'(f_tc), 32'(vecs[i].exp_tc));
        end

        // Full up-count to all-max, then wrap with a single-cycle tc.
        drive(1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < NFULL - 1; i++) step();
        chk("full_max", 32'(f_count), 32'(MAXV));
        chk("full_max_tc", 32'(f_tc), 32'h0);
        step();
        chk("full_wrap", 32'(f_count), 32'h00);
        chk("full_wrap_tc", 32'(f_tc), 32'h1);
        step();
        chk("full_after", 32'(f_count), 32'h01);
        chk("full_after_tc", 32'(f_tc), 32'h0);

        // Asynchronous reset between clock edges.
        for (int i = 0; i < 9; i++) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(f_count), 32'h00);
        chk("arst_slow_count", 32'(s_count), 32'h00);
        chk("arst_seg", 32'(f_seg), 32'h3F);
        chk("arst_sel", 32'(f_sel), 32'h1);
        chk("arst_tc", 32'(f_tc), 32'h0);
        #2;
        rst_n = 1'b1;

        // Load colliding with the 4th-cycle tick on the PRESCALE=4 instance.
        drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step();
        chk("coll_pre", 32'(s_count), 32'h00);
        drive(1'b1, 8'h42, 1'b1, 1'b1, 1'b0);
        step();
        chk("coll_count", 32'(s_count), 32'h42);
        chk("coll_tc", 32'(s_tc), 32'h0);
        drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step();
        chk("coll_wait_up", 32'(s_count), 32'h42);
        step();
        chk("coll_up", 32'(s_count), 32'h43);
        drive(1'b1, 8'h42, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step();
        chk("coll_wait_dn", 32'(s_count), 32'h42);
        step();
        chk("coll_dn", 32'(s_count), 32'h41);

        // Display scan of 0x81 while paused.
        #2;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        drive(1'b1, 8'h81, 1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            logic       idx1;
            logic [1:0] esel;
            logic [6:0] eseg;
            step();
            load = 1'b0;
            idx1 = (((k - 1) / 4) % 2) == 1;
            esel = idx1 ? 2'b10 : 2'b01;
            eseg = idx1 ? 7'h7F : 7'h06;
            if (k >= 2) begin
                chk($sformatf("scan_sel%0d", k), 32'(f_sel), 32'(esel));
                chk($sformatf("scan_seg%0d", k), 32'(f_seg), 32'(eseg));
                chk($sformatf("scan_dp%0d", k), 32'(f_dp), 32'(!idx1));
            end
        end

        // Decode of a loaded 0x3C on digit 0 (clamped 9 in BCD, C in hex).
        drive(1'b1, 8'h3C, 1'b0, 1'b1, 1'b0);
        step();
        load = 1'b0;
        begin
            bit found = 1'b0;
            for (int i = 0; i < 12 && !found; i++) begin
                step();
                if (f_sel == 2'b01) found = 1'b1;
            end
            if (found) begin
                chk("dec3c_seg", 32'(f_seg), 32'(SEG3C));
            end else begin
                chk("dec3c_timeout", 32'h0, 32'h1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
